mem_dump_engine: RTL

//   Synthesizable read-back engine for the processor's word-addressed memories (data or instruction).
//   On a start pulse it reads num_words consecutive words from base_addr through a synchronous read port.
//   It streams the words out on a valid/ready interface with a last flag, so the host side can capture memory contents without simulator hooks.

---
 rtl/mem_dump_engine.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_dump_engine.sv
// mem_dump_engine: reads a run of consecutive words from a synchronous-read
// memory and streams them out over valid/ready, tagging the final word.
// A 2-entry output FIFO absorbs the one-cycle read latency so the stream can
// run at one word per clock while still honouring sink backpressure.
module mem_dump_engine #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN
  } state_t;

  state_t state, state_next;

  // Words still to be requested from memory
  logic [ADDR_W:0] remaining;

  // A read was issued last cycle; its data is on mem_rdata this cycle
  logic inflight;
  logic inflight_last;

  // Output FIFO: two entries, each holding a word and its last tag
  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_last;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic       push;
  logic       pop;
  logic       issue;
  logic       last_issue;
  logic [2:0] occupancy;

  assign push = inflight;
  assign pop  = out_valid && out_ready;

  // Entries that will be held after this cycle if no new read is issued;
  // a read is only issued when its word is guaranteed a free FIFO slot.
  assign occupancy  = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue      = (state == RUN) && (occupancy < 3'd2);
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));

  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last  = out_valid && fifo_last[rd_ptr];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and status/read-enable outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_ren    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_words == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        mem_ren = issue;
        if (last_issue) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Read address, remaining-word counter and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_raddr     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if ((state == IDLE) && start) begin
        mem_raddr <= base_addr;
        remaining <= num_words;
      end else if (issue) begin
        mem_raddr <= mem_raddr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
      end
    end
  end

  // Output FIFO: capture returning read data, release on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_last <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
